// File: rtl/twiddle_menu_ctrl.sv
// twiddle_menu_ctrl: encoder/button menu that browses and edits a bank of config registers.
module twiddle_menu_ctrl #(
  parameter int NREG           = 4,
  parameter int WIDTH          = 8,
  parameter int MAXVAL         = 255,
  parameter int LONG_CYCLES    = 8000000,
  parameter int TIMEOUT_CYCLES = 80000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  step_up,
  input  logic                  step_down,
  input  logic                  btn_n,
  output logic [1:0]            sel,
  output logic                  editing,
  output logic [NREG*WIDTH-1:0] regs,
  output logic                  cfg_we,
  output logic [1:0]            cfg_addr,
  output logic [WIDTH-1:0]      cfg_data,
  output logic [3:0]            leds
);
  localparam int CW = $clog2(LONG_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WIDTH-1:0] MAXV    = WIDTH'(MAXVAL);
  localparam logic [1:0]       LAST    = 2'(NREG - 1);
  localparam logic [CW-1:0]    LONG_V  = CW'(LONG_CYCLES);
  localparam logic [CW-1:0]    LONG_M1 = CW'(LONG_CYCLES - 1);
  localparam logic [TW-1:0]    TMO_M1  = TW'(TIMEOUT_CYCLES - 1);
  typedef enum logic {BROWSE, EDIT} state_t;
  state_t                state_q, state_d;
  logic [1:0]            sel_q, sel_d, addr_q;
  logic [NREG*WIDTH-1:0] regs_q, regs_d;
  logic [WIDTH-1:0]      shadow_q, shadow_d, data_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [3:0]            leds_q, leds_d;
  logic                  btn_prev_q, long_fired_q, long_fired_d, we_q, we_d;
  logic                  press, up, dn, long_ev, short_ev, tmo_ev, idle_clr;
  always_comb begin
    press        = ~btn_n;
    up           = step_up & ~step_down & ~press;
    dn           = step_down & ~step_up & ~press;
    long_ev      = press & ~long_fired_q & (cnt_q == LONG_M1);
    short_ev     = btn_n & ~btn_prev_q & ~long_fired_q;
    cnt_d        = press ? (cnt_q == LONG_V ? cnt_q : cnt_q + 1'b1) : '0;
    long_fired_d = press & (long_fired_q | long_ev);
    idle_clr     = up | dn | press;
    tmo_ev       = (state_q == EDIT) & ~idle_clr & (tmo_q == TMO_M1);
    tmo_d        = (state_q == EDIT && !idle_clr) ? tmo_q + 1'b1 : '0;
    state_d      = state_q;
    sel_d        = sel_q;
    regs_d       = regs_q;
    shadow_d     = shadow_q;
    we_d         = 1'b0;
    if (state_q == BROWSE) begin
      if (short_ev) begin
        state_d  = EDIT;
        shadow_d = regs_q[int'(sel_q)*WIDTH +: WIDTH];
      end else if (long_ev) regs_d = '0;
      else if (up) sel_d = sel_q == LAST ? 2'd0 : sel_q + 2'd1;
      else if (dn) sel_d = sel_q == 2'd0 ? LAST : sel_q - 2'd1;
    end else if (short_ev) begin
      state_d                             = BROWSE;
      regs_d[int'(sel_q)*WIDTH +: WIDTH]  = shadow_q;
      we_d                                = 1'b1;
    end else if (long_ev || tmo_ev) state_d = BROWSE;
    else if (up) shadow_d = shadow_q == MAXV ? shadow_q : shadow_q + 1'b1;
    else if (dn) shadow_d = shadow_q == '0 ? shadow_q : shadow_q - 1'b1;
    leds_d = state_d == EDIT ? shadow_d[3:0] : 4'b0001 << sel_d;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= BROWSE;
      sel_q        <= '0;
      regs_q       <= '0;
      shadow_q     <= '0;
      cnt_q        <= '0;
      tmo_q        <= '0;
      btn_prev_q   <= 1'b1;
      long_fired_q <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      leds_q       <= 4'b0001;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      regs_q       <= regs_d;
      shadow_q     <= shadow_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
      btn_prev_q   <= btn_n;
      long_fired_q <= long_fired_d;
      we_q         <= we_d;
      addr_q       <= we_d ? sel_q : addr_q;
      data_q       <= we_d ? shadow_q : data_q;
      leds_q       <= leds_d;
    end
  end
  assign sel      = sel_q;
  assign editing  = state_q == EDIT;
  assign regs     = regs_q;
  assign cfg_we   = we_q;
  assign cfg_addr = addr_q;
  assign cfg_data = data_q;
  assign leds     = leds_q;
endmodule

// File: tb/tb_twiddle_menu_ctrl.sv
// tb_twiddle_menu_ctrl: directed vector table plus multi-cycle sequences for the menu controller.
module tb_twiddle_menu_ctrl;
  localparam int NREG = 4, WIDTH = 8;
  logic clk = 0, rst = 1, step_up = 0, step_down = 0, btn_n = 1;
  logic [1:0] sel, cfg_addr;
  logic editing, cfg_we;
  logic [NREG*WIDTH-1:0] regs;
  logic [WIDTH-1:0] cfg_data;
  logic [3:0] leds;
  int checks = 0, errors = 0, we_cnt = 0;
  always #5 clk = ~clk;
  twiddle_menu_ctrl #(.NREG(NREG), .WIDTH(WIDTH), .MAXVAL(255), .LONG_CYCLES(16), .TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .rst(rst), .step_up(step_up), .step_down(step_down), .btn_n(btn_n),
    .sel(sel), .editing(editing), .regs(regs), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .leds(leds)
  );
  always @(negedge clk) if (cfg_we) we_cnt++;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick(input logic u, input logic d, input logic b);
    step_up = u; step_down = d; btn_n = b;
    @(posedge clk); #1;
  endtask
  task automatic short_press();
    tick(0, 0, 0);
    tick(0, 0, 1);
  endtask
  typedef struct {
    logic u, d, b;
    logic [1:0] sel;
    logic ed;
    logic [3:0] leds;
    logic we;
    logic [7:0] data;
  } vec_t;
  vec_t tbl[18];
  initial begin
    tbl[0]  = '{1, 0, 1, 2'd1, 0, 4'b0010, 0, 8'd0};
    tbl[1]  = '{1, 0, 1, 2'd2, 0, 4'b0100, 0, 8'd0};
    tbl[2]  = '{1, 0, 1, 2'd3, 0, 4'b1000, 0, 8'd0};
    tbl[3]  = '{1, 0, 1, 2'd0, 0, 4'b0001, 0, 8'd0};
    tbl[4]  = '{1, 0, 1, 2'd1, 0, 4'b0010, 0, 8'd0};
    tbl[5]  = '{0, 1, 1, 2'd0, 0, 4'b0001, 0, 8'd0};
    tbl[6]  = '{0, 1, 1, 2'd3, 0, 4'b1000, 0, 8'd0};
    tbl[7]  = '{1, 1, 1, 2'd3, 0, 4'b1000, 0, 8'd0};
    tbl[8]  = '{0, 1, 1, 2'd2, 0, 4'b0100, 0, 8'd0};
    tbl[9]  = '{0, 0, 0, 2'd2, 0, 4'b0100, 0, 8'd0};
    tbl[10] = '{0, 0, 1, 2'd2, 1, 4'b0000, 0, 8'd0};
    tbl[11] = '{1, 0, 1, 2'd2, 1, 4'b0001, 0, 8'd0};
    tbl[12] = '{1, 0, 1, 2'd2, 1, 4'b0010, 0, 8'd0};
    tbl[13] = '{1, 0, 1, 2'd2, 1, 4'b0011, 0, 8'd0};
    tbl[14] = '{1, 1, 1, 2'd2, 1, 4'b0011, 0, 8'd0};
    tbl[15] = '{1, 0, 0, 2'd2, 1, 4'b0011, 0, 8'd0};
    tbl[16] = '{0, 0, 1, 2'd2, 0, 4'b0100, 1, 8'd3};
    tbl[17] = '{0, 0, 1, 2'd2, 0, 4'b0100, 0, 8'd0};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sel", sel, 0);
    chk("rst_editing", editing, 0);
    chk("rst_regs", regs, 0);
    chk("rst_we", cfg_we, 0);
    chk("rst_leds", leds, 4'b0001);
    rst = 0;
    for (int i = 0; i < 18; i++) begin
      tick(tbl[i].u, tbl[i].d, tbl[i].b);
      chk($sformatf("v%0d_sel", i), sel, tbl[i].sel);
      chk($sformatf("v%0d_editing", i), editing, tbl[i].ed);
      chk($sformatf("v%0d_leds", i), leds, tbl[i].leds);
      chk($sformatf("v%0d_we", i), cfg_we, tbl[i].we);
      if (tbl[i].we) begin
        chk($sformatf("v%0d_addr", i), cfg_addr, 2'd2);
        chk($sformatf("v%0d_data", i), cfg_data, tbl[i].data);
      end
    end
    chk("commit_count", we_cnt, 1);
    chk("commit_regs", regs, {8'd0, 8'd3, 8'd0, 8'd0});
    // saturation at both ends
    short_press();
    chk("sat_enter", {editing, leds}, {1'b1, 4'd3});
    repeat (251) tick(1, 0, 1);
    chk("sat_254", leds, 4'he);
    for (int k = 0; k < 4; k++) begin
      tick(1, 0, 1);
      chk($sformatf("sat_hi%0d", k), {editing, leds}, {1'b1, 4'hf});
    end
    repeat (254) tick(0, 1, 1);
    chk("sat_1", leds, 4'd1);
    for (int k = 0; k < 3; k++) begin
      tick(0, 1, 1);
      chk($sformatf("sat_lo%0d", k), {editing, leds}, {1'b1, 4'd0});
    end
    // long press abandons edit on exactly the 16th held cycle
    for (int h = 1; h <= 20; h++) begin
      tick(0, 0, 0);
      chk($sformatf("long_h%0d", h), editing, h < 16);
    end
    tick(0, 0, 1);
    chk("long_release", editing, 0);
    tick(0, 0, 1);
    chk("long_after", editing, 0);
    chk("long_no_we", we_cnt, 1);
    chk("long_regs", regs[23:16], 8'd3);
    // idle timeout, restarted by a step at cycle 40
    short_press();
    chk("tmo_enter", {editing, leds}, {1'b1, 4'd3});
    for (int c = 1; c <= 90; c++) begin
      tick(c == 40, 0, 1);
      chk($sformatf("tmo_c%0d", c), editing, c < 90);
    end
    chk("tmo_regs", regs[23:16], 8'd3);
    chk("tmo_no_we", we_cnt, 1);
    // long press in browse clears the bank
    for (int h = 1; h <= 16; h++) begin
      tick(0, 0, 0);
      if (h == 15) chk("clr_h15", regs[23:16], 8'd3);
    end
    chk("clr_regs", regs, 0);
    chk("clr_sel", sel, 2);
    tick(0, 0, 1);
    chk("clr_release", editing, 0);
    chk("clr_no_we", we_cnt, 1);
    short_press();
    chk("c1_enter", {editing, leds}, {1'b1, 4'd0});
    tick(1, 0, 1);
    chk("c1_leds", leds, 4'd1);
    tick(0, 0, 0);
    tick(0, 0, 1);
    chk("c1_we", {cfg_we, cfg_addr, cfg_data}, {1'b1, 2'd2, 8'd1});
    chk("c1_regs", regs, {8'd0, 8'd1, 8'd0, 8'd0});
    // asynchronous reset mid-edit with the button held
    short_press();
    tick(1, 0, 1);
    chk("r_leds_pre", {editing, leds}, {1'b1, 4'd2});
    tick(0, 0, 0);
    tick(0, 0, 0);
    #2 rst = 1;
    #1;
    chk("r_sel", sel, 0);
    chk("r_editing", editing, 0);
    chk("r_regs", regs, 0);
    chk("r_cfg", {cfg_we, cfg_addr, cfg_data}, 0);
    chk("r_leds", leds, 4'b0001);
    @(posedge clk); #1;
    rst = 0;
    for (int k = 0; k < 3; k++) begin
      tick(0, 0, 1);
      chk($sformatf("r_post%0d", k), {editing, leds, sel}, {1'b0, 4'b0001, 2'd0});
    end
    chk("final_we_count", we_cnt, 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/twiddle_menu_ctrl.md
Name: twiddle_menu_ctrl

Overview:
Menu controller for the twiddleboard front panel. It consumes the rotary encoder's one-cycle step pulses and the debounced pushbutton level, and uses them to browse and edit a bank of NREG configuration registers. It produces a register-write handshake for downstream consumers and drives the four panel indicators (LED, PIN_1..PIN_3). It sits between the debounced input blocks and the rest of the design, sequencing which register the dial currently controls.

Parameters:
NREG, 4, number of config registers (2..4); sel width is 2 bits
WIDTH, 8, register width in bits
MAXVAL, 255, saturation ceiling for edited values (must be <= 2^WIDTH-1)
LONG_CYCLES, 8000000, button hold time in clk cycles that counts as a long press (0.5 s at 16 MHz)
TIMEOUT_CYCLES, 80000000, idle cycles in EDIT before automatic abandon

Ports:
clk  in  1  system clock, 16 MHz
rst  in  1  reset; one clock, reset is asynchronous and active-high
step_up  in  1  one-cycle pulse per encoder detent, clockwise
step_down  in  1  one-cycle pulse per encoder detent, anticlockwise
btn_n  in  1  debounced button level (pull-up input, so 0 = pressed)
sel  out  2  currently selected register index
editing  out  1  1 while in EDIT
regs  out  NREG*WIDTH  committed register bank, flat; reg i at [i*WIDTH +: WIDTH]
cfg_we  out  1  one-cycle write strobe on commit
cfg_addr  out  2  register index written, valid when cfg_we = 1
cfg_data  out  WIDTH  value written, valid when cfg_we = 1
leds  out  4  indicator drive; leds[0] -> LED, leds[3:1] -> PIN_3..PIN_1

Behaviour:
- Reset (async, any time, including mid-edit or mid-press) sets the following and discards any edit in progress:
  - state = BROWSE, sel = 0, all regs = 0, shadow = 0
  - cfg_we = 0, cfg_addr = 0, cfg_data = 0
  - btn_prev = 1, press counter = 0, long_fired = 0, timeout counter = 0
- Button tracking:
  - press = btn_n is 0. The press counter increments each cycle while pressed and saturates at LONG_CYCLES.
  - When the counter reaches LONG_CYCLES, a long-press event fires exactly once, in that cycle, while the button is still held. long_fired is then set.
  - On release (btn_n rises 0->1): if long_fired = 0, a short-press event fires in the release cycle. Otherwise no event. Both the counter and long_fired clear on release.
- Step qualification:
  - A step is valid only when exactly one of step_up/step_down is 1 and the button is not pressed.
  - Both asserted in the same cycle: ignored.
- State BROWSE:
  - Valid step_up: sel <= (sel == NREG-1) ? 0 : sel+1. Valid step_down wraps 0 -> NREG-1.
  - Short press: shadow <= regs[sel], state <= EDIT, timeout counter cleared.
  - Long press: all regs <= 0, sel unchanged, no cfg_we.
- State EDIT:
  - Valid step_up: shadow <= min(shadow+1, MAXVAL). Valid step_down: shadow <= max(shadow-1, 0). No wrap.
  - Short press (commit), next cycle:
    - regs[sel] <= shadow
    - cfg_we = 1 for exactly one cycle, with cfg_addr = sel and cfg_data = shadow
    - state <= BROWSE
  - Long press: discard shadow, state <= BROWSE, no write.
  - Timeout counter increments each cycle and clears on any valid step or on button press.
  - Timeout counter reaching TIMEOUT_CYCLES: discard, state <= BROWSE, no write.
  - sel is frozen throughout EDIT.
- Outputs:
  - editing = (state == EDIT).
  - leds in BROWSE: one-hot of sel (sel = 2 -> 4'b0100).
  - leds in EDIT: shadow[3:0].
  - All outputs are registered. Step or press to visible output change is 1 cycle.
- Arithmetic: shadow compares are unsigned at WIDTH bits. Saturation must not overflow at MAXVAL = 2^WIDTH-1.

Test Plan:
1. Reset, then 5 step_up pulses with NREG=4 -> sel sequence 1,2,3,0,1; leds = 4'b0010 at the end; cfg_we never asserts.
2. sel=2, short press, 3 step_up, short press -> one cfg_we pulse with cfg_addr=2, cfg_data=3; regs[2]=3; editing back to 0.
3. EDIT with shadow=MAXVAL-1: 4 step_up -> shadow holds MAXVAL. From shadow=1: 3 step_down -> shadow holds 0. leds track shadow[3:0] throughout.
4. In EDIT (LONG_CYCLES=16 for sim), hold btn_n=0 for 20 cycles, then release -> editing drops exactly at cycle 16 of the hold; no cfg_we; release produces no short-press (state stays BROWSE).
5. In EDIT (TIMEOUT_CYCLES=50): step at cycle 40, then idle -> still EDIT at cycle 89, BROWSE at cycle 90; regs unchanged. Separately: step_up and step_down together -> no change.
6. Assert rst mid-edit while the button is held -> all outputs at reset values immediately, asynchronously. After rst deasserts, the release produces no short-press because btn_prev=1 masks it.
